// File: rtl/mmu_tlb.sv
// rtl/mmu_tlb.sv - MMU with fixed-mapped kseg0/kseg1 and a shared fully-associative dual-page TLB
// Two independent translation channels (instruction/data), each with a one-entry registered response stage.
module mmu_tlb #(
  parameter int TLB_ENTRIES = 16,
  parameter int ASID_W      = 8,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ASID_W-1:0] asid,
  input  logic              k0_uncached,
  input  logic [IDX_W-1:0]  wired,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [31:0]       i_req_vaddr,
  output logic              i_resp_valid,
  input  logic              i_resp_ready,
  output logic [31:0]       i_resp_paddr,
  output logic              i_resp_uncached,
  output logic [1:0]        i_resp_exc,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic [31:0]       d_req_vaddr,
  input  logic              d_req_write,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [31:0]       d_resp_paddr,
  output logic              d_resp_uncached,
  output logic [1:0]        d_resp_exc,

  input  logic              tlbw_en,
  input  logic [IDX_W-1:0]  tlbw_index,
  input  logic [18:0]       tlbw_vpn2,
  input  logic [ASID_W-1:0] tlbw_asid,
  input  logic              tlbw_g,
  input  logic [19:0]       tlbw_pfn0,
  input  logic [19:0]       tlbw_pfn1,
  input  logic              tlbw_v0,
  input  logic              tlbw_d0,
  input  logic              tlbw_c0,
  input  logic              tlbw_v1,
  input  logic              tlbw_d1,
  input  logic              tlbw_c1,

  input  logic              probe_valid,
  input  logic [18:0]       probe_vpn2,
  output logic              probe_done,
  output logic              probe_hit,
  output logic [IDX_W-1:0]  probe_index,

  output logic [IDX_W-1:0]  random_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TLB_ENTRIES - 1);

  typedef struct packed {
    logic [31:0] paddr;
    logic        uncached;
    logic [1:0]  exc;
  } xlate_t;

  logic [TLB_ENTRIES-1:0] ent_present;
  logic [TLB_ENTRIES-1:0] ent_g;
  logic [TLB_ENTRIES-1:0] ent_v0, ent_d0, ent_c0;
  logic [TLB_ENTRIES-1:0] ent_v1, ent_d1, ent_c1;
  logic [18:0]            ent_vpn2 [TLB_ENTRIES];
  logic [ASID_W-1:0]      ent_asid [TLB_ENTRIES];
  logic [19:0]            ent_pfn0 [TLB_ENTRIES];
  logic [19:0]            ent_pfn1 [TLB_ENTRIES];

  logic [TLB_ENTRIES-1:0] asid_ok, i_match, d_match, p_match;

  for (genvar k = 0; k < TLB_ENTRIES; k++) begin : g_match
    assign asid_ok[k] = ent_g[k] || (ent_asid[k] == asid);
    assign i_match[k] = ent_present[k] && asid_ok[k] && (ent_vpn2[k] == i_req_vaddr[31:13]);
    assign d_match[k] = ent_present[k] && asid_ok[k] && (ent_vpn2[k] == d_req_vaddr[31:13]);
    assign p_match[k] = ent_present[k] && asid_ok[k] && (ent_vpn2[k] == probe_vpn2);
  end

  // Scanning downward leaves the lowest matching index as the winner.
  function automatic logic [IDX_W-1:0] first_idx(input logic [TLB_ENTRIES-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = TLB_ENTRIES - 1; k >= 0; k--) begin
      if (m[k]) r = IDX_W'(k);
    end
    return r;
  endfunction

  function automatic xlate_t translate(input logic [31:0] va, input logic wr, input logic k0u,
                                       input logic hit, input logic v, input logic d,
                                       input logic c, input logic [19:0] pfn);
    xlate_t r;
    r = '0;
    if (va[31:30] == 2'b10) begin
      r.paddr    = {3'b000, va[28:0]};
      r.uncached = va[29] | k0u;
    end else if (!hit) begin
      r.exc = 2'd1;
    end else if (!v) begin
      r.exc = 2'd2;
    end else if (wr && !d) begin
      r.exc = 2'd3;
    end else begin
      r.paddr    = {pfn, va[11:0]};
      r.uncached = c;
    end
    return r;
  endfunction

  logic [IDX_W-1:0] i_idx, d_idx;
  xlate_t           i_xl, d_xl;

  always_comb begin
    i_idx = first_idx(i_match);
    if (i_req_vaddr[12])
      i_xl = translate(i_req_vaddr, 1'b0, k0_uncached, |i_match,
                       ent_v1[i_idx], ent_d1[i_idx], ent_c1[i_idx], ent_pfn1[i_idx]);
    else
      i_xl = translate(i_req_vaddr, 1'b0, k0_uncached, |i_match,
                       ent_v0[i_idx], ent_d0[i_idx], ent_c0[i_idx], ent_pfn0[i_idx]);
  end

  always_comb begin
    d_idx = first_idx(d_match);
    if (d_req_vaddr[12])
      d_xl = translate(d_req_vaddr, d_req_write, k0_uncached, |d_match,
                       ent_v1[d_idx], ent_d1[d_idx], ent_c1[d_idx], ent_pfn1[d_idx]);
    else
      d_xl = translate(d_req_vaddr, d_req_write, k0_uncached, |d_match,
                       ent_v0[d_idx], ent_d0[d_idx], ent_c0[d_idx], ent_pfn0[d_idx]);
  end

  // Entry storage; lookups this cycle see the pre-write contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_present <= '0;
    end else if (tlbw_en) begin
      ent_present[tlbw_index] <= 1'b1;
      ent_g[tlbw_index]       <= tlbw_g;
      ent_v0[tlbw_index]      <= tlbw_v0;
      ent_d0[tlbw_index]      <= tlbw_d0;
      ent_c0[tlbw_index]      <= tlbw_c0;
      ent_v1[tlbw_index]      <= tlbw_v1;
      ent_d1[tlbw_index]      <= tlbw_d1;
      ent_c1[tlbw_index]      <= tlbw_c1;
      ent_vpn2[tlbw_index]    <= tlbw_vpn2;
      ent_asid[tlbw_index]    <= tlbw_asid;
      ent_pfn0[tlbw_index]    <= tlbw_pfn0;
      ent_pfn1[tlbw_index]    <= tlbw_pfn1;
    end
  end

  logic i_accept, d_accept;
  assign i_req_ready = !i_resp_valid || i_resp_ready;
  assign d_req_ready = !d_resp_valid || d_resp_ready;
  assign i_accept    = i_req_valid && i_req_ready;
  assign d_accept    = d_req_valid && d_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      i_resp_valid    <= 1'b0;
      i_resp_paddr    <= '0;
      i_resp_uncached <= 1'b0;
      i_resp_exc      <= '0;
    end else if (i_accept) begin
      i_resp_valid    <= 1'b1;
      i_resp_paddr    <= i_xl.paddr;
      i_resp_uncached <= i_xl.uncached;
      i_resp_exc      <= i_xl.exc;
    end else if (i_resp_ready) begin
      i_resp_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_resp_valid    <= 1'b0;
      d_resp_paddr    <= '0;
      d_resp_uncached <= 1'b0;
      d_resp_exc      <= '0;
    end else if (d_accept) begin
      d_resp_valid    <= 1'b1;
      d_resp_paddr    <= d_xl.paddr;
      d_resp_uncached <= d_xl.uncached;
      d_resp_exc      <= d_xl.exc;
    end else if (d_resp_ready) begin
      d_resp_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      probe_done  <= 1'b0;
      probe_hit   <= 1'b0;
      probe_index <= '0;
    end else begin
      probe_done <= probe_valid;
      if (probe_valid) begin
        probe_hit   <= |p_match;
        probe_index <= first_idx(p_match);
      end
    end
  end

  // Wraps at or below wired; a wired value >= LAST_IDX pins the counter at LAST_IDX.
  always_ff @(posedge clk) begin
    if (reset)
      random_index <= LAST_IDX;
    else if (random_index <= wired)
      random_index <= LAST_IDX;
    else
      random_index <= random_index - 1'b1;
  end

endmodule

// File: tb/tb_mmu_tlb.sv
// tb/tb_mmu_tlb.sv - directed self-checking bench for mmu_tlb
module tb_mmu_tlb;
  localparam int N  = 16;
  localparam int AW = 8;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] asid;
  logic k0_uncached;
  logic [IW-1:0] wired;
  logic i_req_valid, i_req_ready, i_resp_valid, i_resp_ready, i_resp_uncached;
  logic [31:0] i_req_vaddr, i_resp_paddr;
  logic [1:0] i_resp_exc;
  logic d_req_valid, d_req_ready, d_req_write, d_resp_valid, d_resp_ready, d_resp_uncached;
  logic [31:0] d_req_vaddr, d_resp_paddr;
  logic [1:0] d_resp_exc;
  logic tlbw_en, tlbw_g, tlbw_v0, tlbw_d0, tlbw_c0, tlbw_v1, tlbw_d1, tlbw_c1;
  logic [IW-1:0] tlbw_index;
  logic [18:0] tlbw_vpn2;
  logic [AW-1:0] tlbw_asid;
  logic [19:0] tlbw_pfn0, tlbw_pfn1;
  logic probe_valid, probe_done, probe_hit;
  logic [18:0] probe_vpn2;
  logic [IW-1:0] probe_index, random_index;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmu_tlb #(.TLB_ENTRIES(N), .ASID_W(AW)) dut (
    .clk(clk), .reset(reset), .asid(asid), .k0_uncached(k0_uncached), .wired(wired),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_vaddr(i_req_vaddr),
    .i_resp_valid(i_resp_valid), .i_resp_ready(i_resp_ready), .i_resp_paddr(i_resp_paddr),
    .i_resp_uncached(i_resp_uncached), .i_resp_exc(i_resp_exc),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_vaddr(d_req_vaddr),
    .d_req_write(d_req_write), .d_resp_valid(d_resp_valid), .d_resp_ready(d_resp_ready),
    .d_resp_paddr(d_resp_paddr), .d_resp_uncached(d_resp_uncached), .d_resp_exc(d_resp_exc),
    .tlbw_en(tlbw_en), .tlbw_index(tlbw_index), .tlbw_vpn2(tlbw_vpn2), .tlbw_asid(tlbw_asid),
    .tlbw_g(tlbw_g), .tlbw_pfn0(tlbw_pfn0), .tlbw_pfn1(tlbw_pfn1),
    .tlbw_v0(tlbw_v0), .tlbw_d0(tlbw_d0), .tlbw_c0(tlbw_c0),
    .tlbw_v1(tlbw_v1), .tlbw_d1(tlbw_d1), .tlbw_c1(tlbw_c1),
    .probe_valid(probe_valid), .probe_vpn2(probe_vpn2), .probe_done(probe_done),
    .probe_hit(probe_hit), .probe_index(probe_index), .random_index(random_index)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic d_req(input logic [31:0] va, input logic wr);
    d_req_vaddr = va;
    d_req_write = wr;
    d_req_valid = 1'b1;
    tick();
    d_req_valid = 1'b0;
  endtask

  task automatic i_req(input logic [31:0] va);
    i_req_vaddr = va;
    i_req_valid = 1'b1;
    tick();
    i_req_valid = 1'b0;
  endtask

  task automatic set_entry(input logic [IW-1:0] idx, input logic [18:0] vpn2, input logic [AW-1:0] a,
                           input logic g, input logic [19:0] p0, input logic v0, input logic d0,
                           input logic c0, input logic [19:0] p1, input logic v1, input logic d1,
                           input logic c1);
    tlbw_index = idx; tlbw_vpn2 = vpn2; tlbw_asid = a; tlbw_g = g;
    tlbw_pfn0 = p0; tlbw_v0 = v0; tlbw_d0 = d0; tlbw_c0 = c0;
    tlbw_pfn1 = p1; tlbw_v1 = v1; tlbw_d1 = d1; tlbw_c1 = c1;
    tlbw_en = 1'b1;
  endtask

  task automatic tlb_wr(input logic [IW-1:0] idx, input logic [18:0] vpn2, input logic [AW-1:0] a,
                        input logic g, input logic [19:0] p0, input logic v0, input logic d0,
                        input logic c0, input logic [19:0] p1, input logic v1, input logic d1,
                        input logic c1);
    set_entry(idx, vpn2, a, g, p0, v0, d0, c0, p1, v1, d1, c1);
    tick();
    tlbw_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++; if (i_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_i_valid got %b exp 0", i_resp_valid); end
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid got %b exp 0", d_resp_valid); end
    checks++; if (probe_done !== 1'b0 || probe_hit !== 1'b0 || probe_index !== 4'd0) begin
      errors++; $display("FAIL reset_probe got done=%b hit=%b idx=%0d exp 0/0/0", probe_done, probe_hit, probe_index); end
    checks++; if (random_index !== 4'd15) begin errors++; $display("FAIL reset_random got %0d exp 15", random_index); end
    reset = 1'b0;
  endtask

  task automatic test_unmapped();
    k0_uncached = 1'b0;
    i_req(32'hBFC0_0000);
    checks++; if (i_resp_valid !== 1'b1 || i_resp_paddr !== 32'h1FC0_0000 || i_resp_uncached !== 1'b1 || i_resp_exc !== 2'd0) begin
      errors++; $display("FAIL kseg1_i got v=%b pa=%h unc=%b exc=%0d exp 1/1fc00000/1/0", i_resp_valid, i_resp_paddr, i_resp_uncached, i_resp_exc); end
    d_req(32'h8000_1234, 1'b0);
    checks++; if (d_resp_valid !== 1'b1 || d_resp_paddr !== 32'h0000_1234 || d_resp_uncached !== 1'b0 || d_resp_exc !== 2'd0) begin
      errors++; $display("FAIL kseg0_d got v=%b pa=%h unc=%b exc=%0d exp 1/00001234/0/0", d_resp_valid, d_resp_paddr, d_resp_uncached, d_resp_exc); end
    tick();
    checks++; if (i_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      errors++; $display("FAIL resp_clear got i=%b d=%b exp 0/0", i_resp_valid, d_resp_valid); end
    k0_uncached = 1'b1;
    d_req(32'h8000_1234, 1'b1);
    checks++; if (d_resp_uncached !== 1'b1 || d_resp_exc !== 2'd0) begin
      errors++; $display("FAIL kseg0_k0unc got unc=%b exc=%0d exp 1/0", d_resp_uncached, d_resp_exc); end
    k0_uncached = 1'b0;
  endtask

  task automatic test_mapped();
    asid = 8'd5;
    tlb_wr(4'd3, 19'h00010, 8'd5, 1'b0, 20'h12345, 1'b1, 1'b0, 1'b0, 20'h54321, 1'b1, 1'b1, 1'b1);
    d_req(32'h0002_0ABC, 1'b0);
    checks++; if (d_resp_paddr !== 32'h1234_5ABC || d_resp_exc !== 2'd0 || d_resp_uncached !== 1'b0) begin
      errors++; $display("FAIL even_read got pa=%h exc=%0d unc=%b exp 12345abc/0/0", d_resp_paddr, d_resp_exc, d_resp_uncached); end
    d_req(32'h0002_0ABC, 1'b1);
    checks++; if (d_resp_exc !== 2'd3 || d_resp_paddr !== 32'h0) begin
      errors++; $display("FAIL modified got exc=%0d pa=%h exp 3/0", d_resp_exc, d_resp_paddr); end
    d_req(32'h0002_1ABC, 1'b1);
    checks++; if (d_resp_paddr !== 32'h5432_1ABC || d_resp_exc !== 2'd0 || d_resp_uncached !== 1'b1) begin
      errors++; $display("FAIL odd_write got pa=%h exc=%0d unc=%b exp 54321abc/0/1", d_resp_paddr, d_resp_exc, d_resp_uncached); end
    i_req(32'h0002_1ABC);
    checks++; if (i_resp_paddr !== 32'h5432_1ABC || i_resp_exc !== 2'd0) begin
      errors++; $display("FAIL odd_ifetch got pa=%h exc=%0d exp 54321abc/0", i_resp_paddr, i_resp_exc); end
    asid = 8'd6;
    d_req(32'h0002_0ABC, 1'b0);
    checks++; if (d_resp_exc !== 2'd1 || d_resp_paddr !== 32'h0) begin
      errors++; $display("FAIL asid_miss got exc=%0d pa=%h exp 1/0", d_resp_exc, d_resp_paddr); end
    tlb_wr(4'd3, 19'h00010, 8'd5, 1'b1, 20'h12345, 1'b1, 1'b0, 1'b0, 20'h54321, 1'b1, 1'b1, 1'b1);
    d_req(32'h0002_0ABC, 1'b0);
    checks++; if (d_resp_paddr !== 32'h1234_5ABC || d_resp_exc !== 2'd0) begin
      errors++; $display("FAIL global_hit got pa=%h exc=%0d exp 12345abc/0", d_resp_paddr, d_resp_exc); end
    tlb_wr(4'd3, 19'h00010, 8'd5, 1'b1, 20'h12345, 1'b0, 1'b0, 1'b0, 20'h54321, 1'b1, 1'b1, 1'b1);
    d_req(32'h0002_0000, 1'b0);
    checks++; if (d_resp_exc !== 2'd2 || d_resp_paddr !== 32'h0 || d_resp_uncached !== 1'b0) begin
      errors++; $display("FAIL invalid got exc=%0d pa=%h unc=%b exp 2/0/0", d_resp_exc, d_resp_paddr, d_resp_uncached); end
    // A duplicate at a higher index must lose to entry 3
    tlb_wr(4'd7, 19'h00010, 8'd0, 1'b1, 20'hAAAAA, 1'b1, 1'b1, 1'b0, 20'hBBBBB, 1'b1, 1'b1, 1'b0);
    d_req(32'h0002_0000, 1'b0);
    checks++; if (d_resp_exc !== 2'd2) begin
      errors++; $display("FAIL multi_hit_even got exc=%0d exp 2", d_resp_exc); end
    d_req(32'h0002_1000, 1'b0);
    checks++; if (d_resp_paddr !== 32'h5432_1000) begin
      errors++; $display("FAIL multi_hit_odd got pa=%h exp 54321000", d_resp_paddr); end
    i_req(32'h7FFF_E000);
    checks++; if (i_resp_exc !== 2'd1) begin
      errors++; $display("FAIL refill_i got exc=%0d exp 1", i_resp_exc); end
    asid = 8'd5;
  endtask

  task automatic test_backpressure();
    d_resp_ready = 1'b0;
    d_req(32'h8000_0010, 1'b0);
    d_req_vaddr = 32'h8000_0020;
    d_req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (d_resp_valid !== 1'b1 || d_resp_paddr !== 32'h10 || d_req_ready !== 1'b0) begin
        errors++; $display("FAIL hold_%0d got v=%b pa=%h rdy=%b exp 1/00000010/0", k, d_resp_valid, d_resp_paddr, d_req_ready); end
    end
    d_resp_ready = 1'b1;
    tick();
    d_req_valid = 1'b0;
    checks++; if (d_resp_valid !== 1'b1 || d_resp_paddr !== 32'h20) begin
      errors++; $display("FAIL release got v=%b pa=%h exp 1/00000020", d_resp_valid, d_resp_paddr); end
    tick();
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL drain got %b exp 0", d_resp_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      d_req_vaddr = 32'h8000_0100 + 32'(k * 4);
      d_req_write = 1'b0;
      d_req_valid = 1'b1;
      tick();
      checks++; if (d_resp_valid !== 1'b1 || d_resp_paddr !== 32'h100 + 32'(k * 4)) begin
        errors++; $display("FAIL b2b_%0d got v=%b pa=%h exp 1/%h", k, d_resp_valid, d_resp_paddr, 32'h100 + 32'(k * 4)); end
    end
    d_req_valid = 1'b0;
    tick();
    checks++; if (d_resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", d_resp_valid); end
  endtask

  task automatic test_same_cycle_write();
    tlb_wr(4'd2, 19'h00020, 8'd0, 1'b1, 20'h11111, 1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    set_entry(4'd2, 19'h00020, 8'd0, 1'b1, 20'h22222, 1'b1, 1'b1, 1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
    d_req(32'h0004_0004, 1'b0);
    tlbw_en = 1'b0;
    checks++; if (d_resp_paddr !== 32'h1111_1004) begin
      errors++; $display("FAIL same_cycle_old got pa=%h exp 11111004", d_resp_paddr); end
    d_req(32'h0004_0004, 1'b0);
    checks++; if (d_resp_paddr !== 32'h2222_2004) begin
      errors++; $display("FAIL after_write_new got pa=%h exp 22222004", d_resp_paddr); end
  endtask

  task automatic test_probe();
    probe_vpn2 = 19'h00010;
    probe_valid = 1'b1;
    tick();
    probe_vpn2 = 19'h7FFFF;
    tick();
    probe_valid = 1'b0;
    checks++; if (probe_done !== 1'b1 || probe_hit !== 1'b0 || probe_index !== 4'd0) begin
      errors++; $display("FAIL probe_miss got done=%b hit=%b idx=%0d exp 1/0/0", probe_done, probe_hit, probe_index); end
    probe_vpn2 = 19'h00010;
    probe_valid = 1'b1;
    tick();
    probe_valid = 1'b0;
    checks++; if (probe_done !== 1'b1 || probe_hit !== 1'b1 || probe_index !== 4'd3) begin
      errors++; $display("FAIL probe_hit got done=%b hit=%b idx=%0d exp 1/1/3", probe_done, probe_hit, probe_index); end
    tick();
    checks++; if (probe_done !== 1'b0) begin errors++; $display("FAIL probe_pulse got %b exp 0", probe_done); end
  endtask

  task automatic test_random();
    logic [IW-1:0] exp_r;
    wired = 4'd4;
    d_resp_ready = 1'b0;
    d_req(32'h8000_0040, 1'b0);
    reset = 1'b1;
    tick();
    checks++; if (d_resp_valid !== 1'b0 || random_index !== 4'd15) begin
      errors++; $display("FAIL reset_mid got v=%b rnd=%0d exp 0/15", d_resp_valid, random_index); end
    reset = 1'b0;
    d_resp_ready = 1'b1;
    exp_r = 4'd15;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) set_entry(exp_r, 19'h00100, 8'd0, 1'b1, 20'h0, 1'b1, 1'b1, 1'b0, 20'h0, 1'b1, 1'b1, 1'b0);
      tick();
      tlbw_en = 1'b0;
      exp_r = (exp_r <= 4'd4) ? 4'd15 : exp_r - 4'd1;
      checks++; if (random_index !== exp_r) begin
        errors++; $display("FAIL random_%0d got %0d exp %0d", k, random_index, exp_r); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (random_index !== 4'd15) begin errors++; $display("FAIL random_reset got %0d exp 15", random_index); end
    wired = 4'd15;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (random_index !== 4'd15) begin
        errors++; $display("FAIL random_pinned_%0d got %0d exp 15", k, random_index); end
    end
    d_req(32'h0002_0ABC, 1'b0);
    checks++; if (d_resp_exc !== 2'd1) begin
      errors++; $display("FAIL cleared_entries got exc=%0d exp 1", d_resp_exc); end
  endtask

  initial begin
    reset = 1'b1; asid = '0; k0_uncached = 1'b0; wired = '0;
    i_req_valid = 1'b0; i_req_vaddr = '0; i_resp_ready = 1'b1;
    d_req_valid = 1'b0; d_req_vaddr = '0; d_req_write = 1'b0; d_resp_ready = 1'b1;
    tlbw_en = 1'b0; tlbw_index = '0; tlbw_vpn2 = '0; tlbw_asid = '0; tlbw_g = 1'b0;
    tlbw_pfn0 = '0; tlbw_pfn1 = '0; tlbw_v0 = 1'b0; tlbw_d0 = 1'b0; tlbw_c0 = 1'b0;
    tlbw_v1 = 1'b0; tlbw_d1 = 1'b0; tlbw_c1 = 1'b0;
    probe_valid = 1'b0; probe_vpn2 = '0;
    test_reset();
    test_unmapped();
    test_mapped();
    test_backpressure();
    test_back_to_back();
    test_same_cycle_write();
    test_probe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmu_tlb.md
Name: mmu_tlb

Overview:
Parametrised MMU translating instruction and data virtual addresses to physical addresses ahead of the I/D caches. Unmapped segments (0x8000_0000–0xBFFF_FFFF) use fixed translation. All other segments go through a shared fully-associative TLB with TLB_ENTRIES dual-page entries. It adds a registered one-entry response stage per channel with valid/ready handshake, TLB write/probe ports, a Random index counter and per-access exception codes.

Parameters:
TLB_ENTRIES, 16, number of TLB entries (power of two, 4..64)
ASID_W, 8, address-space ID width
IDX_W, $clog2(TLB_ENTRIES), index width (derived)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
asid  in  ASID_W  current address-space ID
k0_uncached  in  1  kseg0 accesses are uncached when 1
wired  in  IDX_W  lowest index Random may return
i_req_valid / i_req_ready  in / out  1  instruction request handshake
i_req_vaddr  in  32  instruction virtual address
i_resp_valid / i_resp_ready  out / in  1  instruction response handshake
i_resp_paddr  out  32  translated address (0 on exception)
i_resp_uncached  out  1  access bypasses cache
i_resp_exc  out  2  0 none, 1 refill, 2 invalid, 3 modified
d_req_valid, d_req_ready, d_req_vaddr, d_req_write  in/out/in/in  1/1/32/1  data request; write=store
d_resp_valid, d_resp_ready, d_resp_paddr, d_resp_uncached, d_resp_exc  out/in/out/out/out  1/1/32/1/2  data response, same encoding
tlbw_en  in  1  write entry tlbw_index
tlbw_index  in  IDX_W  target entry
tlbw_vpn2  in  19  vaddr[31:13]
tlbw_asid  in  ASID_W  entry ASID
tlbw_g  in  1  global
tlbw_pfn0, tlbw_pfn1  in  20 each  even/odd page frame
tlbw_v0, tlbw_d0, tlbw_c0  in  1 each  even valid/dirty/uncached
tlbw_v1, tlbw_d1, tlbw_c1  in  1 each  odd valid/dirty/uncached
probe_valid  in  1  start probe
probe_vpn2  in  19  probe VPN2; uses current asid
probe_done  out  1  one-cycle pulse, result valid
probe_hit  out  1  match found
probe_index  out  IDX_W  matching index (0 if miss)
random_index  out  IDX_W  replacement index for TLBWR

Behaviour:
- Reset: all resp_valid, probe_done, probe_hit and probe_index = 0; random_index = TLB_ENTRIES-1; every entry's internal present bit cleared. Non-present entries never hit. Reset in mid-transaction drops held responses.
- Channels are independent and identical; both may translate in the same cycle.
- Handshake: req_ready = !resp_valid || resp_ready. A request is accepted on valid&&ready. Its result is registered and appears at resp_valid on the next cycle, giving 1-cycle latency and full throughput when resp_ready=1. The resp_* outputs hold stable while resp_valid && !resp_ready. resp_valid clears when resp_ready is high and no new request is accepted.
- Unmapped translation (vaddr[31:30]==2'b10): paddr = {3'b0, vaddr[28:0]}; uncached = vaddr[29] ? 1 : k0_uncached; exc = 0.
- Mapped translation:
  - An entry hits if present && vpn2==vaddr[31:13] && (g || asid==entry asid).
  - vaddr[12] selects the odd page (1) or even page (0).
  - No hit: exc = 1 (refill).
  - Hit with selected v=0: exc = 2.
  - Data write hitting a page with v=1 and d=0: exc = 3.
  - Otherwise paddr = {pfn, vaddr[11:0]} and uncached = c.
  - Multiple hits: the lowest index wins.
  - Whenever exc != 0, paddr = 0 and uncached = 0.
- TLB write: takes effect at the clock edge. A lookup or probe in the same cycle sees the old contents. A write sets present=1.
- Probe: compares vpn2, asid and g; v bits are ignored. probe_done pulses 1 cycle after probe_valid, with hit/index registered. A new probe may be issued every cycle.
- Random: decrements every cycle. When it equals wired, or is below it, the next value is TLB_ENTRIES-1. A tlbw_en with tlbw_index == random_index does not alter the sequence. If wired >= TLB_ENTRIES-1, random_index holds TLB_ENTRIES-1.

Test Plan:
- After reset, request i_vaddr 0xBFC0_0000 → next cycle i_resp_valid=1, paddr 0x1FC0_0000, uncached=1, exc=0. With k0_uncached=0, d read 0x8000_1234 → paddr 0x0000_1234, uncached=0.
- Write entry 3 (vpn2 0x00010, asid 5, g=0, pfn0 0x12345, v0=1, d0=0, pfn1 0x54321, v1=1, d1=1) with asid=5:
  - d read 0x0002_0ABC → paddr 0x1234_5ABC, exc 0.
  - d write 0x0002_0ABC → exc 3.
  - read 0x0002_1ABC → paddr 0x5432_1ABC.
- Same entry with asid=6 → exc 1. After rewriting the entry with g=1 → hit. After rewriting with v0=0 and g=1, access 0x0002_0000 → exc 2.
- Hold d_resp_ready=0 for 3 cycles after one accept:
  - resp stable and d_req_ready=0.
  - Back-to-back requests with ready=1 each produce one response per cycle, in order.
  - A tlbw_en in the same cycle as a lookup of that page returns the old mapping.
- Probe vpn2 0x00010 after the entry-3 write → probe_done next cycle, hit=1, index=3. Probe an unmapped vpn2 → hit=0, index=0.
- With wired=4 and TLB_ENTRIES=16, random sequence is 15,14,…,4,15,… ; assert reset mid-sequence → 15.
